btn_debounce_n: RTL
===================

// Module: btn_debounce_n
// PURPOSE
//  Conditions N raw, active-low push-button inputs for the stopwatch core.
//  - Each channel is synchronised, then debounced.
//  - Outputs are clean active-low levels that drive i_fStart, i_fStop and
//    i_fRecord directly, plus one-cycle press and release pulses.
//  - Sits between the board pins and the stopwatch. Idle outputs are high, so
//    the stopwatch's falling-edge detect sees no edge after reset.
// PARAMETERS
//  N_BTN        3            number of button channels
//  CLK_HZ       100_000_000  i_Clk frequency in Hz
//  DEBOUNCE_MS  10           time an input must stay stable, in ms
//  (localparam) DB_CYC = CLK_HZ/1000*DEBOUNCE_MS; LST_CNT = DB_CYC-1;
//               counter width = $clog2(DB_CYC); DB_CYC >= 2 required
// PORTS
//  i_Clk       in   1      system clock, rising edge
//  i_Rst       in   1      asynchronous reset, active-high
//  i_Btn       in   N_BTN  raw button inputs, active-low, asynchronous to i_Clk
//  o_Btn       out  N_BTN  debounced level, active-low (1 = released)
//  o_fPress    out  N_BTN  1-cycle pulse when o_Btn[i] goes 1->0
//  o_fRelease  out  N_BTN  1-cycle pulse when o_Btn[i] goes 0->1
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-high.
//  - Reset values:
//    - both synchroniser flops of every channel = 1;
//    - every channel FSM = RELEASED, counter = 0;
//    - o_Btn = all 1s, o_fPress = 0, o_fRelease = 0.
//  - Synchroniser: 2 flops per channel; s_Btn[i] is the second flop's output.
//  - FSM per channel, states RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK:
//    - RELEASED: o_Btn=1. If s_Btn=0: go to PRESS_CHK, cnt=0.
//    - PRESS_CHK:
//      - if s_Btn=1: go to RELEASED, cnt=0 (bounce rejected, no pulse);
//      - else if cnt==LST_CNT: go to PRESSED; o_Btn<=0 and o_fPress<=1 on
//        the same edge;
//      - else cnt++.
//    - PRESSED: o_Btn=0. If s_Btn=1: go to RELEASE_CHK, cnt=0.
//    - RELEASE_CHK:
//      - if s_Btn=0: go to PRESSED, cnt=0;
//      - else if cnt==LST_CNT: go to RELEASED; o_Btn<=1 and o_fRelease<=1;
//      - else cnt++.
//  - All outputs are registered.
//    - o_fPress and o_fRelease are high for exactly 1 cycle, then return to 0.
//    - They are never high together on the same channel.
//  - Latency: raw input stable from sample edge 0 -> o_Btn changes after edge
//    DB_CYC+2 (2 synchroniser edges + 1 entry edge + DB_CYC-1 counts + 1).
//  - Glitches: a glitch shorter than DB_CYC cycles after synchronisation never
//    changes o_Btn and produces no pulse.
//  - Counter: counts only in the CHK states, never wraps, and is cleared on
//    every CHK entry.
//  - Channels are fully independent.
//    - Simultaneous presses give simultaneous pulse bits.
//    - A held button never repeats its pulse.
//  - Reset mid-operation:
//    - any state or count is abandoned immediately; outputs go to their reset
//      values with no pulse;
//    - if a button is held low through reset release, the channel runs a full
//      debounce and then emits o_fPress.
// TESTING  (N_BTN=3, CLK_HZ=4000, DEBOUNCE_MS=1 -> DB_CYC=4)
//  1. Reset asserted mid-PRESS_CHK with i_Btn=3'b110 -> o_Btn=3'b111, no
//     pulses; after release, o_Btn[0] falls after edge 6 of the restarted
//     sequence.
//  2. i_Btn[0] 1->0, held -> o_Btn[0]=0 and o_fPress=3'b001 after edge 6,
//     pulse gone after edge 7; no further pulses while held.
//  3. i_Btn[1] low for 3 cycles, then high -> o_Btn stays 3'b111, no pulses.
//  4. Press bounces 0,1,0 (1 cycle each), then stays 0 -> a single o_fPress[2]
//     pulse, 6 edges after the final low is first sampled.
//  5. Release of held ch0 -> o_Btn[0]=1 and o_fRelease=3'b001 after edge 6.
//  6. Channels 0 and 2 pressed on the same edge -> o_fPress=3'b101 in one
//     cycle, o_Btn=3'b010.

Source files
------------

// File: rtl/btn_debounce_n_if.sv
// Button conditioner bundle: raw active-low pins in, debounced levels and
// one-cycle press/release pulses out, plus per-channel FSM state for debug.
interface btn_debounce_n_if #(
    parameter int N_BTN = 3
);
    logic [N_BTN-1:0]   i_Btn;
    logic [N_BTN-1:0]   o_Btn;
    logic [N_BTN-1:0]   o_fPress;
    logic [N_BTN-1:0]   o_fRelease;
    logic [2*N_BTN-1:0] dbg_state;

    modport master (
        output i_Btn,
        input  o_Btn,
        input  o_fPress,
        input  o_fRelease,
        input  dbg_state
    );

    modport slave (
        input  i_Btn,
        output o_Btn,
        output o_fPress,
        output o_fRelease,
        output dbg_state
    );
endinterface

// File: rtl/btn_debounce_n.sv
// N-channel push-button conditioner: 2-flop synchroniser plus a 4-state
// debounce FSM per channel, producing registered levels and edge pulses.
module btn_debounce_n #(
    parameter int N_BTN       = 3,
    parameter int CLK_HZ      = 100_000_000,
    parameter int DEBOUNCE_MS = 10
) (
    input logic              i_Clk,
    input logic              i_Rst,
    btn_debounce_n_if.slave  bus
);
    localparam int DB_CYC  = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int LST_CNT = DB_CYC - 1;
    localparam int CW      = $clog2(DB_CYC);

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    localparam logic [CW-1:0] LST = CW'(LST_CNT);

    logic [N_BTN-1:0] sync1_q, sync1_d;
    logic [N_BTN-1:0] sync2_q, sync2_d;
    logic [N_BTN-1:0] s_btn;
    state_t           state_q [N_BTN];
    state_t           state_d [N_BTN];
    logic [CW-1:0]    cnt_q   [N_BTN];
    logic [CW-1:0]    cnt_d   [N_BTN];
    logic [N_BTN-1:0] btn_q, btn_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] release_q, release_d;

    // Synchroniser flops reset to 1 so a released (high) pin shows no edge.
    always_comb begin
        sync1_d = bus.i_Btn;
        sync2_d = sync1_q;
    end

    assign s_btn = sync2_q;

    // State register (also holds synchroniser, counters and output flops).
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            btn_q     <= '1;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= RELEASED;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            btn_q     <= btn_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Next-state and counter logic; the counter is only meaningful in CHK states.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                RELEASED: begin
                    if (!s_btn[i]) begin
                        state_d[i] = PRESS_CHK;
                        cnt_d[i]   = '0;
                    end
                end
                PRESS_CHK: begin
                    if (s_btn[i]) begin
                        state_d[i] = RELEASED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == LST) begin
                        state_d[i] = PRESSED;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                PRESSED: begin
                    if (s_btn[i]) begin
                        state_d[i] = RELEASE_CHK;
                        cnt_d[i]   = '0;
                    end
                end
                RELEASE_CHK: begin
                    if (!s_btn[i]) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == LST) begin
                        state_d[i] = RELEASED;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                default: begin
                    state_d[i] = RELEASED;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Output logic: level and pulse flops update on the edge that confirms.
    always_comb begin
        btn_d     = btn_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < N_BTN; i++) begin
            case (state_q[i])
                PRESS_CHK: begin
                    if (!s_btn[i] && cnt_q[i] == LST) begin
                        btn_d[i]   = 1'b0;
                        press_d[i] = 1'b1;
                    end
                end
                RELEASE_CHK: begin
                    if (s_btn[i] && cnt_q[i] == LST) begin
                        btn_d[i]     = 1'b1;
                        release_d[i] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.dbg_state = '0;
        for (int i = 0; i < N_BTN; i++) begin
            bus.dbg_state[2*i +: 2] = state_q[i];
        end
    end

    assign bus.o_Btn      = btn_q;
    assign bus.o_fPress   = press_q;
    assign bus.o_fRelease = release_q;
endmodule
